// File: rtl/hsci_link_init_pkg.sv
// Shared types for the HSCI link bring-up controller: FSM states, error codes
// and small state-decoding helpers used to build the registered status outputs.
package hsci_link_init_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_WAIT_SEQ,
      ST_WAIT_BSC,
      ST_STABLE,
      ST_READY,
      ST_FAIL
   } link_state_t;

   localparam logic [2:0] ERR_NONE           = 3'd0;
   localparam logic [2:0] ERR_LOCK_TIMEOUT   = 3'd1;
   localparam logic [2:0] ERR_SEQ_TIMEOUT    = 3'd2;
   localparam logic [2:0] ERR_BSC_TIMEOUT    = 3'd3;
   localparam logic [2:0] ERR_STABLE_TIMEOUT = 3'd4;
   localparam logic [2:0] ERR_LOCK_LOST      = 3'd5;

   function automatic logic pll_reset_for(input link_state_t s);
      return (s == ST_IDLE) || (s == ST_PLL_RST) || (s == ST_FAIL);
   endfunction

   function automatic logic busy_for(input link_state_t s);
      return !((s == ST_IDLE) || (s == ST_READY) || (s == ST_FAIL));
   endfunction

endpackage

// File: rtl/hsci_bit_sync.sv
// Plain two-flop synchronizer for a bundle of independent asynchronous status bits.
module hsci_bit_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta     <= '0;
         sync_out <= '0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/hsci_link_init.sv
// HSCI link bring-up sequencer: pulses the PLL reset, waits for lock, bitslice
// reset sequencing and VTC/delay readiness, then qualifies stability with retries.
module hsci_link_init
   import hsci_link_init_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = 64,
   parameter int unsigned WAIT_TIMEOUT   = 65536,
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter bit          AUTO_RESTART   = 1'b1
) (
   input  logic       s_axi_aclk,
   input  logic       s_axi_areset,
   input  logic       init_start,
   output logic       hsci_pll_reset,
   input  logic       hsci_pll_locked,
   input  logic       hsci_rst_seq_done,
   input  logic       hsci_vtc_rdy_bsc_tx,
   input  logic       hsci_dly_rdy_bsc_tx,
   input  logic       hsci_vtc_rdy_bsc_rx,
   input  logic       hsci_dly_rdy_bsc_rx,
   output logic       link_ready,
   output logic       init_busy,
   output logic       init_error,
   output logic [2:0] err_code,
   output logic [3:0] retry_count
);

   localparam int PW = $clog2(PLL_RST_CYCLES + 1);
   localparam int TW = $clog2(WAIT_TIMEOUT + 1);
   localparam int SW = $clog2(STABLE_CYCLES + 1);

   link_state_t state, state_nxt;
   logic [PW-1:0] pll_cnt, pll_cnt_nxt;
   logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic [SW-1:0] stb_cnt, stb_cnt_nxt;
   logic [2:0]    err_nxt, fault_code;
   logic [3:0]    retry_nxt;
   logic          fault;

   logic [5:0] sync_bits;
   logic       locked_s, seq_done_s, vtc_tx_s, dly_tx_s, vtc_rx_s, dly_rx_s;
   logic       bsc_rdy, all_good, timeout;

   hsci_bit_sync #(.WIDTH(6)) u_sync (
      .clk      (s_axi_aclk),
      .reset    (s_axi_areset),
      .async_in ({hsci_pll_locked, hsci_rst_seq_done, hsci_vtc_rdy_bsc_tx,
                  hsci_dly_rdy_bsc_tx, hsci_vtc_rdy_bsc_rx, hsci_dly_rdy_bsc_rx}),
      .sync_out (sync_bits)
   );

   assign {locked_s, seq_done_s, vtc_tx_s, dly_tx_s, vtc_rx_s, dly_rx_s} = sync_bits;
   assign bsc_rdy  = vtc_tx_s & dly_tx_s & vtc_rx_s & dly_rx_s;
   assign all_good = locked_s & seq_done_s & bsc_rdy;
   assign timeout  = (tmo_cnt == TW'(WAIT_TIMEOUT - 1));

   // The timeout check precedes every advance so that an expiring budget wins.
   always_comb begin
      state_nxt   = state;
      pll_cnt_nxt = pll_cnt;
      tmo_cnt_nxt = tmo_cnt;
      stb_cnt_nxt = stb_cnt;
      err_nxt     = err_code;
      retry_nxt   = retry_count;
      fault       = 1'b0;
      fault_code  = ERR_NONE;

      if ((state == ST_WAIT_LOCK) || (state == ST_WAIT_SEQ) ||
          (state == ST_WAIT_BSC) || (state == ST_STABLE))
         tmo_cnt_nxt = tmo_cnt + TW'(1);

      case (state)
         ST_IDLE, ST_FAIL: begin
            if (init_start) begin
               state_nxt   = ST_PLL_RST;
               pll_cnt_nxt = '0;
               retry_nxt   = '0;
               err_nxt     = ERR_NONE;
            end
         end
         ST_PLL_RST: begin
            if (pll_cnt == PW'(PLL_RST_CYCLES - 1)) begin
               state_nxt   = ST_WAIT_LOCK;
               tmo_cnt_nxt = '0;
            end else begin
               pll_cnt_nxt = pll_cnt + PW'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (timeout) begin
               fault      = 1'b1;
               fault_code = ERR_LOCK_TIMEOUT;
            end else if (locked_s) begin
               state_nxt = ST_WAIT_SEQ;
            end
         end
         ST_WAIT_SEQ: begin
            if (timeout) begin
               fault      = 1'b1;
               fault_code = ERR_SEQ_TIMEOUT;
            end else if (seq_done_s) begin
               state_nxt = ST_WAIT_BSC;
            end
         end
         ST_WAIT_BSC: begin
            if (timeout) begin
               fault      = 1'b1;
               fault_code = ERR_BSC_TIMEOUT;
            end else if (bsc_rdy) begin
               state_nxt   = ST_STABLE;
               stb_cnt_nxt = '0;
            end
         end
         ST_STABLE: begin
            if (timeout) begin
               fault      = 1'b1;
               fault_code = ERR_STABLE_TIMEOUT;
            end else if (!all_good) begin
               stb_cnt_nxt = '0;
            end else if (stb_cnt == SW'(STABLE_CYCLES - 1)) begin
               state_nxt = ST_READY;
            end else begin
               stb_cnt_nxt = stb_cnt + SW'(1);
            end
         end
         ST_READY: begin
            if (!locked_s) begin
               if (AUTO_RESTART) begin
                  fault      = 1'b1;
                  fault_code = ERR_LOCK_LOST;
               end else begin
                  err_nxt   = ERR_LOCK_LOST;
                  state_nxt = ST_FAIL;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Retry budget is checked before incrementing, so the count saturates.
      if (fault) begin
         err_nxt = fault_code;
         if (retry_count < 4'(MAX_RETRIES)) begin
            retry_nxt   = retry_count + 4'd1;
            state_nxt   = ST_PLL_RST;
            pll_cnt_nxt = '0;
         end else begin
            state_nxt = ST_FAIL;
         end
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         state          <= ST_IDLE;
         pll_cnt        <= '0;
         tmo_cnt        <= '0;
         stb_cnt        <= '0;
         err_code       <= ERR_NONE;
         retry_count    <= '0;
         hsci_pll_reset <= 1'b1;
         link_ready     <= 1'b0;
         init_busy      <= 1'b0;
         init_error     <= 1'b0;
      end else begin
         state          <= state_nxt;
         pll_cnt        <= pll_cnt_nxt;
         tmo_cnt        <= tmo_cnt_nxt;
         stb_cnt        <= stb_cnt_nxt;
         err_code       <= err_nxt;
         retry_count    <= retry_nxt;
         hsci_pll_reset <= pll_reset_for(state_nxt);
         link_ready     <= (state_nxt == ST_READY);
         init_busy      <= busy_for(state_nxt);
         init_error     <= (state_nxt == ST_FAIL);
      end
   end

endmodule

// File: tb/tb_hsci_link_init.sv
// Directed-plus-random bench for hsci_link_init; expectations come from cycle
// arithmetic on attempt length, sync latency and the stable/timeout windows.
module tb_hsci_link_init;

   localparam int PLL_C = 4;
   localparam int TMO_C = 100;
   localparam int STB_C = 8;
   localparam int ATTEMPT = PLL_C + TMO_C;

   logic clk = 1'b0;
   logic areset, init_start, locked, seq_done, vtc_tx, dly_tx, vtc_rx, dly_rx;
   logic a_pll, a_ready, a_busy, a_error, b_pll, b_ready, b_busy, b_error;
   logic [2:0] a_err, b_err;
   logic [3:0] a_retry, b_retry;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hsci_link_init #(.PLL_RST_CYCLES(PLL_C), .WAIT_TIMEOUT(TMO_C), .STABLE_CYCLES(STB_C),
                    .MAX_RETRIES(2), .AUTO_RESTART(1'b1)) dut_a (
      .s_axi_aclk(clk), .s_axi_areset(areset), .init_start(init_start),
      .hsci_pll_reset(a_pll), .hsci_pll_locked(locked), .hsci_rst_seq_done(seq_done),
      .hsci_vtc_rdy_bsc_tx(vtc_tx), .hsci_dly_rdy_bsc_tx(dly_tx),
      .hsci_vtc_rdy_bsc_rx(vtc_rx), .hsci_dly_rdy_bsc_rx(dly_rx),
      .link_ready(a_ready), .init_busy(a_busy), .init_error(a_error),
      .err_code(a_err), .retry_count(a_retry));

   hsci_link_init #(.PLL_RST_CYCLES(PLL_C), .WAIT_TIMEOUT(TMO_C), .STABLE_CYCLES(STB_C),
                    .MAX_RETRIES(2), .AUTO_RESTART(1'b0)) dut_b (
      .s_axi_aclk(clk), .s_axi_areset(areset), .init_start(init_start),
      .hsci_pll_reset(b_pll), .hsci_pll_locked(locked), .hsci_rst_seq_done(seq_done),
      .hsci_vtc_rdy_bsc_tx(vtc_tx), .hsci_dly_rdy_bsc_tx(dly_tx),
      .hsci_vtc_rdy_bsc_rx(vtc_rx), .hsci_dly_rdy_bsc_rx(dly_rx),
      .link_ready(b_ready), .init_busy(b_busy), .init_error(b_error),
      .err_code(b_err), .retry_count(b_retry));

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkDut(input string tag, input bit use_b, input bit e_pll, input bit e_rdy,
                           input bit e_busy, input bit e_error, input logic [7:0] e_err,
                           input logic [7:0] e_retry);
      checkOutput({tag, " pll_reset"},   {7'd0, use_b ? b_pll   : a_pll},   {7'd0, e_pll});
      checkOutput({tag, " link_ready"},  {7'd0, use_b ? b_ready : a_ready}, {7'd0, e_rdy});
      checkOutput({tag, " init_busy"},   {7'd0, use_b ? b_busy  : a_busy},  {7'd0, e_busy});
      checkOutput({tag, " init_error"},  {7'd0, use_b ? b_error : a_error}, {7'd0, e_error});
      checkOutput({tag, " err_code"},    {5'd0, use_b ? b_err   : a_err},   e_err);
      checkOutput({tag, " retry_count"}, {4'd0, use_b ? b_retry : a_retry}, e_retry);
   endtask

   task automatic applyStimulus(input bit st, input bit lk, input bit sq, input bit [3:0] rdy);
      init_start = st;
      locked     = lk;
      seq_done   = sq;
      {vtc_tx, dly_tx, vtc_rx, dly_rx} = rdy;
   endtask

   task automatic applyReset();
      areset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
      repeat (3) nextCycle();
      checkDut("reset A", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      checkDut("reset B", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      areset = 1'b0;
      nextCycle();
   endtask

   // Leaves the bench at the negedge just after the edge that sampled init_start (k = 0).
   task automatic startInit();
      init_start = 1'b1;
      nextCycle();
      init_start = 1'b0;
   endtask

   // Inputs raised after edge d are first seen by the FSM three edges later.
   task automatic runHappy(input int d);
      int ready_at;
      int e1;
      applyReset();
      repeat (2) nextCycle();
      startInit();
      e1 = (d + 3 > PLL_C + 1) ? d + 3 : PLL_C + 1;
      ready_at = e1 + 2 + STB_C;
      for (int k = 0; k <= ready_at + 3; k++) begin
         checkDut($sformatf("happy d=%0d k=%0d", d, k), 1'b0, k < PLL_C, k >= ready_at,
                  k < ready_at, 1'b0, 8'd0, 8'd0);
         if (k == d) applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
         nextCycle();
      end
   endtask

   task automatic runLockNever();
      int rises;
      int j;
      logic prev_pll;
      applyReset();
      startInit();
      rises = 0;
      prev_pll = 1'b1;
      for (int k = 0; k <= 3 * ATTEMPT + 5 + ATTEMPT; k++) begin
         if (k < 3 * ATTEMPT) begin
            checkDut($sformatf("nolock k=%0d", k), 1'b0, (k % ATTEMPT) < PLL_C, 1'b0, 1'b1, 1'b0,
                     (k >= ATTEMPT) ? 8'd1 : 8'd0, 8'(k / ATTEMPT));
            if (a_pll && !prev_pll) rises++;
            prev_pll = a_pll;
         end else if (k < 3 * ATTEMPT + 5) begin
            checkDut($sformatf("nolock fail k=%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2);
         end else begin
            j = k - (3 * ATTEMPT + 5);
            checkDut($sformatf("nolock restart j=%0d", j), 1'b0, (j % ATTEMPT) < PLL_C, 1'b0,
                     1'b1, 1'b0, (j >= ATTEMPT) ? 8'd1 : 8'd0, (j >= ATTEMPT) ? 8'd1 : 8'd0);
         end
         if (k == 3 * ATTEMPT) checkOutput("nolock pll pulses after first", 8'(rises), 8'd2);
         applyStimulus(k == 3 * ATTEMPT + 4, 1'b0, 1'($urandom), 4'($urandom));
         nextCycle();
      end
   endtask

   task automatic runStableToggle();
      int phase;
      int ready_at;
      applyReset();
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b1110);
      repeat (4) nextCycle();
      startInit();
      phase = int'($urandom_range(0, 4));
      ready_at = ATTEMPT + PLL_C + 3 + 8;
      for (int k = 0; k <= ready_at + 6; k++) begin
         checkDut($sformatf("toggle k=%0d", k), 1'b0,
                  (k < PLL_C) || (k >= ATTEMPT && k < ATTEMPT + PLL_C), k >= ready_at,
                  k < ready_at, 1'b0, (k >= ATTEMPT) ? 8'd4 : 8'd0, (k >= ATTEMPT) ? 8'd1 : 8'd0);
         if (k < ATTEMPT && ((k + phase) % 5) == 0) dly_rx = ~dly_rx;
         if (k == ATTEMPT) dly_rx = 1'b1;
         nextCycle();
      end
   endtask

   task automatic runLockDrop();
      bit a_rdy;
      applyReset();
      applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
      repeat (4) nextCycle();
      startInit();
      for (int k = 0; k <= 42; k++) begin
         a_rdy = (k >= 15 && k < 23) || (k >= 38);
         checkDut($sformatf("drop A k=%0d", k), 1'b0, (k < PLL_C) || (k >= 23 && k < 27), a_rdy,
                  !a_rdy, 1'b0, (k >= 23) ? 8'd5 : 8'd0, (k >= 23) ? 8'd1 : 8'd0);
         if (k < 23)
            checkDut($sformatf("drop B k=%0d", k), 1'b1, k < PLL_C, k >= 15, k < 15, 1'b0,
                     8'd0, 8'd0);
         else
            checkDut($sformatf("drop B k=%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 8'd0);
         if (k == 20) locked = 1'b0;
         if (k == 21) locked = 1'b1;
         nextCycle();
      end
   endtask

   task automatic runIgnoreAndReset();
      applyReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
      repeat (4) nextCycle();
      startInit();
      for (int k = 0; k <= 20; k++) begin
         checkDut($sformatf("ignore k=%0d", k), 1'b0, k < PLL_C, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
         init_start = (k == 10);
         if (k == 12) seq_done = 1'b1;
         if (k == 20) areset = 1'b1;
         nextCycle();
      end
      checkDut("midreset A", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      checkDut("midreset B", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      areset = 1'b0;
      nextCycle();
   endtask

   initial begin
      areset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
      nextCycle();
      runHappy(10);
      runHappy(int'($urandom_range(0, 40)));
      runLockNever();
      runStableToggle();
      runLockDrop();
      runIgnoreAndReset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
